mem_arbiter: RTL and testbench

//  Shares one single-port synchronous RAM between two requesters: instruction fetch (IF) and the MEM stage (load/store).

---
 rtl/mem_arbiter_pkg.sv | 23 ++
 rtl/mem_arb_pick.sv | 28 ++
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the IF/MEM single-port RAM arbiter.
//   arb_state_e : arbiter FSM states
//   arb_gnt_e   : which requester owns the current access
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } arb_state_e;

  typedef enum logic {
    GntIf  = 1'b0,
    GntMem = 1'b1
  } arb_gnt_e;

  // Wide enough for WAIT_STATES up to 7 and STARVE_LIMIT up to 15.
  localparam int unsigned WaitCntWidth   = 3;
  localparam int unsigned StarveCntWidth = 4;

  localparam logic [3:0] BeAll = 4'b1111;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selector for the RAM arbiter.
// MEM wins by default; IF wins when it has been passed over STARVE_LIMIT times in a row.
//   if_req_i     : IF request pending
//   mem_req_i    : MEM request pending
//   starve_cnt_i : consecutive MEM grants seen while IF was waiting
//   gnt_if_o     : grant IF this cycle
//   gnt_mem_o    : grant MEM this cycle (never together with gnt_if_o)
module mem_arb_pick
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                      if_req_i,
  input  logic                      mem_req_i,
  input  logic [StarveCntWidth-1:0] starve_cnt_i,
  output logic                      gnt_if_o,
  output logic                      gnt_mem_o
);

  logic if_starved;

  always_comb begin
    if_starved = (starve_cnt_i == StarveCntWidth'(STARVE_LIMIT));
    gnt_if_o   = if_req_i & (~mem_req_i | if_starved);
    gnt_mem_o  = mem_req_i & ~gnt_if_o;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between instruction fetch (IF) and the MEM stage.
// Each access runs IDLE -> ACCESS (WAIT_STATES+1 cycles) -> RESP (one-cycle done pulse).
//   clk_i, rst_i          : clock, synchronous active-high reset
//   if_req_i/if_addr_i    : IF read request and address, held until if_done_o
//   if_rdata_o/if_done_o  : IF read data (registered) and completion pulse
//   if_stallreq_o         : IF still waiting
//   mem_req_i/we/be/addr/wdata : MEM request fields, held until mem_done_o
//   mem_rdata_o/mem_done_o: MEM read data (registered) and completion pulse
//   mem_stallreq_o        : MEM still waiting
//   ram_*                 : single-port RAM interface; ram_rdata_i valid in last ACCESS cycle
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_done_o,
  output logic                  if_stallreq_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [3:0]            mem_be_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [DATA_WIDTH-1:0] mem_wdata_i,
  output logic [DATA_WIDTH-1:0] mem_rdata_o,
  output logic                  mem_done_o,
  output logic                  mem_stallreq_o,
  output logic                  ram_ce_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  arb_state_e                state_q, state_d;
  arb_gnt_e                  gnt_q, gnt_d;
  logic [WaitCntWidth-1:0]   cnt_q, cnt_d;
  logic [StarveCntWidth-1:0] starve_q, starve_d;
  logic                      we_q, we_d;
  logic [3:0]                be_q, be_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]     mem_rdata_q, mem_rdata_d;

  logic gnt_if, gnt_mem;
  logic in_idle, in_access, in_resp;

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .if_req_i    (if_req_i),
    .mem_req_i   (mem_req_i),
    .starve_cnt_i(starve_q),
    .gnt_if_o    (gnt_if),
    .gnt_mem_o   (gnt_mem)
  );

  assign in_idle   = (state_q == StIdle);
  assign in_access = (state_q == StAccess);
  assign in_resp   = (state_q == StResp);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    unique case (state_q)
      StIdle: begin
        if (gnt_if || gnt_mem) begin
          state_d = StAccess;
          cnt_d   = WaitCntWidth'(WAIT_STATES);
          gnt_d   = gnt_mem ? GntMem : GntIf;
          we_d    = gnt_mem & mem_we_i;
          be_d    = (gnt_mem && mem_we_i) ? mem_be_i : BeAll;
          addr_d  = gnt_mem ? mem_addr_i : if_addr_i;
          wdata_d = gnt_mem ? mem_wdata_i : '0;
        end
      end
      StAccess: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = StResp;
          if (!we_q) begin
            if (gnt_q == GntIf) if_rdata_d = ram_rdata_i;
            else                mem_rdata_d = ram_rdata_i;
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // The guard only tracks an IF request that is actually waiting; any gap resets it.
    starve_d = starve_q;
    if (!if_req_i) begin
      starve_d = '0;
    end else if (in_idle && gnt_if) begin
      starve_d = '0;
    end else if (in_idle && gnt_mem && (starve_q != StarveCntWidth'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      gnt_q       <= GntIf;
      cnt_q       <= '0;
      starve_q    <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // RAM bus is quiet outside ACCESS so reset and idle both present all zeros.
  always_comb begin
    ram_ce_o    = in_access;
    ram_we_o    = in_access & we_q;
    ram_be_o    = in_access ? be_q : '0;
    ram_addr_o  = in_access ? addr_q : '0;
    ram_wdata_o = in_access ? wdata_q : '0;

    if_done_o      = in_resp & (gnt_q == GntIf);
    mem_done_o     = in_resp & (gnt_q == GntMem);
    if_rdata_o     = if_rdata_q;
    mem_rdata_o    = mem_rdata_q;
    if_stallreq_o  = if_req_i & ~if_done_o;
    mem_stallreq_o = mem_req_i & ~mem_done_o;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions (data + cycle),
// a negedge monitor pops and compares on every done pulse.
module tb_mem_arbiter;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ram_init;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // Main DUT (default parameters)
  logic        if_req, if_done, if_stallreq;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_done, mem_stallreq;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        ram_ce, ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  // Zero-wait-state DUT
  logic        if_req0, if_done0, if_stallreq0;
  logic [31:0] if_addr0, if_rdata0;
  logic        mem_req0, mem_we0, mem_done0, mem_stallreq0;
  logic [3:0]  mem_be0;
  logic [31:0] mem_addr0, mem_wdata0, mem_rdata0;
  logic        ram_ce0, ram_we0;
  logic [3:0]  ram_be0;
  logic [31:0] ram_addr0, ram_wdata0, ram_rdata0;

  mem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_done_o(if_done),
    .if_stallreq_o(if_stallreq),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_be_i(mem_be), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_done_o(mem_done),
    .mem_stallreq_o(mem_stallreq),
    .ram_ce_o(ram_ce), .ram_we_o(ram_we), .ram_be_o(ram_be), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  mem_arbiter #(.WAIT_STATES(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(if_req0), .if_addr_i(if_addr0), .if_rdata_o(if_rdata0), .if_done_o(if_done0),
    .if_stallreq_o(if_stallreq0),
    .mem_req_i(mem_req0), .mem_we_i(mem_we0), .mem_be_i(mem_be0), .mem_addr_i(mem_addr0),
    .mem_wdata_i(mem_wdata0), .mem_rdata_o(mem_rdata0), .mem_done_o(mem_done0),
    .mem_stallreq_o(mem_stallreq0),
    .ram_ce_o(ram_ce0), .ram_we_o(ram_we0), .ram_be_o(ram_be0), .ram_addr_o(ram_addr0),
    .ram_wdata_o(ram_wdata0), .ram_rdata_i(ram_rdata0)
  );

  // Word RAM model: 0x10 -> 0x13, 0x100 -> 0x11223344, 0x200 -> 0xCAFEF00D
  logic [31:0] ram_mem [0:255];
  assign ram_rdata  = ram_mem[ram_addr[9:2]];
  assign ram_rdata0 = ram_mem[ram_addr0[9:2]];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
      ram_mem[4]   <= 32'h0000_0013;
      ram_mem[64]  <= 32'h1122_3344;
      ram_mem[128] <= 32'hCAFE_F00D;
    end else if (ram_ce && ram_we) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) ram_mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  exp_t exp_if_q[$];
  exp_t exp_mem_q[$];
  exp_t exp_if0_q[$];
  exp_t mon_e;
  int   we_hits = 0;
  int   we_any  = 0;

  // Monitor: every done pulse must match the oldest expectation for that port.
  always @(negedge clk) begin
    if (ram_ce && ram_we) we_any <= we_any + 1;
    if (ram_ce && ram_we && ram_be == 4'b0011 && ram_addr == 32'h100 &&
        ram_wdata == 32'hDEAD_BEEF)
      we_hits <= we_hits + 1;
    if (if_done) begin
      if (exp_if_q.size() == 0) begin
        check("if_done_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_if_q.pop_front();
        check("if_rdata", if_rdata, mon_e.data);
        check("if_done_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
    if (mem_done) begin
      if (exp_mem_q.size() == 0) begin
        check("mem_done_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_mem_q.pop_front();
        check("mem_rdata", mem_rdata, mon_e.data);
        check("mem_done_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
    if (if_done0) begin
      if (exp_if0_q.size() == 0) begin
        check("ws0_if_done_unexpected", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_if0_q.pop_front();
        check("ws0_if_rdata", if_rdata0, mon_e.data);
        check("ws0_if_done_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles, dropping each request right after its done pulse.
  task automatic run_drop(input int n);
    logic ifd, memd;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ifd  = if_done;
      memd = mem_done;
      tick();
      if (ifd)  if_req  = 1'b0;
      if (memd) mem_req = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   c0, c1, ifc, memc, w0, wa0, ce_n;
    logic ifd, memd;

    rst = 1'b1; ram_init = 1'b1;
    if_req = 0; if_addr = '0; mem_req = 0; mem_we = 0; mem_be = '0; mem_addr = '0;
    mem_wdata = '0;
    if_req0 = 0; if_addr0 = '0; mem_req0 = 0; mem_we0 = 0; mem_be0 = '0; mem_addr0 = '0;
    mem_wdata0 = '0;
    repeat (3) tick();
    rst = 1'b0; ram_init = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ram_ce", 32'(ram_ce), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_ram_be", 32'(ram_be), 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_mem_rdata", mem_rdata, 32'h0);
    check("rst_dones", {30'h0, if_done, mem_done}, 32'h0);
    check("rst_stallreqs", {30'h0, if_stallreq, mem_stallreq}, 32'h0);
    tick();

    // 1. IF-only read of 0x10
    c0 = cyc;
    if_addr = 32'h10; if_req = 1'b1;
    exp_if_q.push_back('{32'h13, c0 + 3});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_ram_ce", 32'(ram_ce), 32'((k == 1) || (k == 2)));
      check("t1_if_stallreq", 32'(if_stallreq), 32'(k != 3));
      if (k == 1) check("t1_ram_addr", ram_addr, 32'h10);
      if (k == 1) check("t1_ram_be_read", 32'(ram_be), 32'hF);
      tick();
    end
    if_req = 1'b0;

    // 2. Simultaneous IF and MEM read: MEM first
    c0 = cyc;
    if_addr = 32'h10; if_req = 1'b1;
    mem_addr = 32'h200; mem_we = 1'b0; mem_req = 1'b1;
    exp_mem_q.push_back('{32'hCAFE_F00D, c0 + 3});
    exp_if_q.push_back('{32'h13, c0 + 7});
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) check("t2_mem_addr", ram_addr, 32'h200);
      if (k == 3) check("t2_if_stall_ungranted", 32'(if_stallreq), 32'h1);
      if (k == 5) check("t2_if_access", {ram_addr[30:0], ram_ce}, {31'h10, 1'b1});
      ifd = if_done; memd = mem_done;
      tick();
      if (ifd)  if_req  = 1'b0;
      if (memd) mem_req = 1'b0;
    end

    // 4. Partial write to 0x100, then read back through MEM
    w0 = we_hits; wa0 = we_any;
    c0 = cyc;
    mem_addr = 32'h100; mem_we = 1'b1; mem_be = 4'b0011; mem_wdata = 32'hDEAD_BEEF;
    mem_req = 1'b1;
    exp_mem_q.push_back('{32'hCAFE_F00D, c0 + 3});
    run_drop(4);
    check("t4_we_be_cycles", 32'(we_hits - w0), 32'd2);
    check("t4_we_cycles", 32'(we_any - wa0), 32'd2);
    mem_we = 1'b0;
    c0 = cyc;
    mem_req = 1'b1;
    exp_mem_q.push_back('{32'h1122_BEEF, c0 + 3});
    run_drop(4);

    // 3. Starvation guard with both requests held
    c0 = cyc;
    if_addr = 32'h10; if_req = 1'b1;
    mem_addr = 32'h200; mem_we = 1'b0; mem_req = 1'b1;
    for (int i = 0; i < 4; i++) exp_mem_q.push_back('{32'hCAFE_F00D, c0 + 3 + 4 * i});
    exp_if_q.push_back('{32'h13, c0 + 19});
    exp_mem_q.push_back('{32'hCAFE_F00D, c0 + 23});
    ifc = 0; memc = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (if_done)  ifc++;
      if (mem_done) memc++;
      if (k == 18) check("t3_mem_before_if", 32'(memc * 16 + ifc), 32'(4 * 16 + 0));
      ifd = if_done; memd = mem_done;
      tick();
      if (ifd) if_req = 1'b0;
      if (memd && memc == 5) mem_req = 1'b0;
    end
    check("t3_if_done_count", 32'(ifc), 32'd1);
    check("t3_mem_done_count", 32'(memc), 32'd5);

    // 5. Reset during the first ACCESS cycle
    c0 = cyc;
    if_addr = 32'h10; if_req = 1'b1;
    tick();
    @(negedge clk);
    check("t5_in_access", 32'(ram_ce), 32'h1);
    rst = 1'b1; if_req = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_ram_bus", {ram_addr[27:0], ram_be}, 32'h0);
    check("t5_ram_ctl", {30'h0, ram_ce, ram_we}, 32'h0);
    check("t5_dones", {30'h0, if_done, mem_done}, 32'h0);
    check("t5_rdata", if_rdata | mem_rdata, 32'h0);
    tick();
    c1 = cyc;
    if_req = 1'b1;
    exp_if_q.push_back('{32'h13, c1 + 3});
    run_drop(4);

    // 6. Zero wait states
    c0 = cyc;
    if_addr0 = 32'h10; if_req0 = 1'b1;
    exp_if0_q.push_back('{32'h13, c0 + 2});
    ce_n = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ram_ce0) ce_n++;
      ifd = if_done0;
      tick();
      if (ifd) if_req0 = 1'b0;
    end
    check("t6_ce_cycles", 32'(ce_n), 32'd1);

    repeat (3) tick();
    check("if_queue_drained", 32'(exp_if_q.size()), 32'd0);
    check("mem_queue_drained", 32'(exp_mem_q.size()), 32'd0);
    check("ws0_queue_drained", 32'(exp_if0_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
